// File: rtl/param_sp_ram_pkg.sv
// param_sp_ram_pkg: shared definitions for the parametrised single-port RAM.
//   - Read-during-write mode codes used by the RD_MODE parameter.
//   - State encoding of the post-reset clear sequencer.
//   - byte_merge(): lane-wise merge of new write data into an old word.
// byte_merge works on a fixed maximum width; callers zero-extend their words
// into it and slice the result back down to their own width.
package param_sp_ram_pkg;

  localparam int unsigned RD_NO_CHANGE   = 0;
  localparam int unsigned RD_READ_FIRST  = 1;
  localparam int unsigned RD_WRITE_FIRST = 2;

  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } init_state_e;

  // Replace byte lane i of old_word with lane i of new_word wherever be[i] is set.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BYTES-1:0]  be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/param_sp_ram_init_seq.sv
// ram_init_seq: clear sequencer for param_sp_ram.
// After reset it walks an address counter from 0 to DEPTH-1, requesting one
// zero-write per cycle, then parks in READY. busy is a registered copy of
// "the state after this edge is CLEAR", so it is glitch-free and depends on
// the FSM state only.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   clr_we   out  clear write request for this cycle
//   clr_addr out  address to clear this cycle
//   busy     out  clear sequence running
module ram_init_seq
  import param_sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam init_state_e       ResetState = (CLEAR_ON_RESET != 0) ? StClear : StReady;
  localparam logic              ResetBusy  = (CLEAR_ON_RESET != 0);
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StReady: begin
        state_d = StReady;
      end
    endcase
    busy_d = (state_d == StClear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      busy_q  <= ResetBusy;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_we   = (state_q == StClear);
  assign clr_addr = cnt_q;
  assign busy     = busy_q;

endmodule

// File: rtl/param_sp_ram.sv
// param_sp_ram: parametrised single-port synchronous RAM.
// Byte-lane writes, selectable read-during-write output, optional output
// pipeline stage, read-valid strobe and a zeroing sequence after reset.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   access request
//   wr_en    in   1 write, 0 read (qualified by en)
//   be       in   byte-lane write enables, bit i covers data_in[8i+7:8i]
//   address  in   word address
//   data_in  in   write data
//   data_out out  read data, held between reads
//   rd_valid out  one-cycle pulse, data_out updated this cycle
//   busy     out  clear sequence running; requests ignored
module param_sp_ram
  import param_sp_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DEPTH          = 1 << ADDR_W,
  parameter int unsigned RD_MODE        = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int unsigned     NumBytes = DATA_W / 8;
  localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("param_sp_ram: DATA_W must be a non-zero multiple of 8 up to MAX_DATA_W");
  end
  if (DEPTH > (1 << ADDR_W) || DEPTH == 0) begin : g_bad_depth
    $error("param_sp_ram: DEPTH must be in 1..2**ADDR_W");
  end
  if (RD_MODE > RD_WRITE_FIRST) begin : g_bad_rd_mode
    $error("param_sp_ram: RD_MODE must be 0, 1 or 2");
  end

  // Clear sequencer
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              init_busy;

  ram_init_seq #(
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_init_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (init_busy)
  );

  assign busy = init_busy;

  // Request decode and write merge
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  addr_ok;
  logic                  accept;
  logic                  rd_req;
  logic                  wr_req;
  logic [DATA_W-1:0]     old_word;
  logic [MAX_DATA_W-1:0] merged_full;
  logic [DATA_W-1:0]     merged_word;

  always_comb begin
    addr_ok = ({1'b0, address} < DepthW);
    accept  = en & ~init_busy & ~rst;
    rd_req  = accept & ~wr_en;
    wr_req  = accept & wr_en;
    // Out-of-range addresses read as zero and never reach the array.
    old_word    = addr_ok ? mem_q[address] : '0;
    merged_full = byte_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(data_in),
                             MAX_BYTES'(be));
    merged_word = merged_full[DATA_W-1:0];
  end

  // Memory array: clear writes take priority; user writes are blocked while busy anyway.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = merged_word;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_req && addr_ok && (be != '0)) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the storage itself; the clear sequence does that job.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // First output stage: captures read data or the write-cycle word.
  logic              s1_fire;
  logic [DATA_W-1:0] s1_word;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;

  always_comb begin
    s1_fire = 1'b0;
    s1_word = old_word;
    if (rd_req) begin
      s1_fire = 1'b1;
    end else if (wr_req) begin
      if (RD_MODE == RD_READ_FIRST) begin
        s1_fire = 1'b1;
        s1_word = old_word;
      end else if (RD_MODE == RD_WRITE_FIRST) begin
        s1_fire = 1'b1;
        s1_word = addr_ok ? merged_word : '0;
      end
    end
    s1_data_d  = s1_fire ? s1_word : s1_data_q;
    s1_valid_d = s1_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // Optional second stage keeps data_out and rd_valid aligned one cycle later.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_valid_q, s2_valid_d;

    always_comb begin
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      s2_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign data_out = s2_data_q;
    assign rd_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign data_out = s1_data_q;
    assign rd_valid = s1_valid_q;
  end

  logic unused_bytes;
  assign unused_bytes = (NumBytes == 0);

endmodule
